// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C register slave.
package i2c_slave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK
  } state_t;

  localparam logic [6:0] DEF_SLAVE_ADDR = 7'h53;
  localparam logic       ACK_LVL        = 1'b0;
  localparam logic       NACK_LVL       = 1'b1;

endpackage

// File: rtl/i2c_slave_sync.sv
// Pad-line synchronizer with level, rise and fall outputs.
// Define I2C_SLAVE_GLITCH_FILTER_EN to add a 3-sample agreement filter (+2 clk).
module i2c_slave_sync (
  input  logic clk,
  input  logic rstn,
  input  logic i_line,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic [1:0] r_sync;
  logic       r_prev;
  logic       w_lvl;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], i_line};
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] r_hist;
  logic       r_held;

  // Pass the new level as soon as three consecutive samples agree.
  assign w_lvl = (r_sync[1] == r_hist[0] && r_hist[0] == r_hist[1]) ? r_sync[1] : r_held;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hist <= 2'b11;
      r_held <= 1'b1;
    end else begin
      r_hist <= {r_hist[0], r_sync[1]};
      r_held <= w_lvl;
    end
  end
`else
  assign w_lvl = r_sync[1];
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_prev <= 1'b1;
    else       r_prev <= w_lvl;
  end

  assign o_lvl  = w_lvl;
  assign o_rise = w_lvl & ~r_prev;
  assign o_fall = ~w_lvl & r_prev;

endmodule

// File: rtl/i2c_slave.sv
// I2C slave exposing REG_DEPTH byte registers behind an auto-incrementing pointer.
// Optional build macro: I2C_SLAVE_GLITCH_FILTER_EN (input glitch filter).
module i2c_slave
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEF_SLAVE_ADDR,
  parameter int         REG_DEPTH  = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic SCL_i,
  input  logic SDA_i,
  output logic SDA_in_en,
  output logic SDA_o
);

  localparam int PW = $clog2(REG_DEPTH);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_cnt, w_cnt_nxt;
  logic [7:0]      r_shreg, w_sh_nxt;
  logic [PW-1:0]   r_ptr, w_ptr_nxt, w_ptr_inc;
  logic            r_first, w_first_nxt;
  logic            r_sda_en, w_en_nxt;
  logic            r_sda_o;
  logic            w_wr_en;
  logic [7:0]      r_regs [REG_DEPTH];
  logic [7:0]      w_cur_byte, w_nxt_byte;

  i2c_slave_sync u_scl (.clk(clk), .rstn(rstn), .i_line(SCL_i),
                        .o_lvl(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall));
  i2c_slave_sync u_sda (.clk(clk), .rstn(rstn), .i_line(SDA_i),
                        .o_lvl(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall));

  assign w_start    = w_sda_fall & w_scl;
  assign w_stop     = w_sda_rise & w_scl;
  assign w_ptr_inc  = r_ptr + 1'b1;
  assign w_cur_byte = r_regs[r_ptr];
  assign w_nxt_byte = r_regs[w_ptr_inc];

  // Open-drain: the enable value is exactly the bus level we present.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sh_nxt    = r_shreg;
    w_ptr_nxt   = r_ptr;
    w_first_nxt = r_first;
    w_en_nxt    = r_sda_en;
    w_wr_en     = 1'b0;
    if (w_stop) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_en_nxt    = 1'b1;
    end else if (w_start) begin
      w_state_nxt = ADDR;
      w_cnt_nxt   = '0;
      w_en_nxt    = 1'b1;
    end else begin
      case (r_state)
        ADDR, WR_DATA: begin
          if (w_scl_rise) begin
            w_sh_nxt  = {r_shreg[6:0], w_sda};
            w_cnt_nxt = r_cnt + 4'd1;
          end else if (w_scl_fall && r_cnt == 4'd8) begin
            if (r_state == ADDR) begin
              if (r_shreg[7:1] == SLAVE_ADDR) begin
                w_state_nxt = ADDR_ACK;
                w_en_nxt    = ACK_LVL;
              end else begin
                w_state_nxt = IDLE;
              end
            end else begin
              w_state_nxt = WR_ACK;
              w_en_nxt    = ACK_LVL;
              w_first_nxt = 1'b0;
              if (r_first) begin
                w_ptr_nxt = r_shreg[PW-1:0];
              end else begin
                w_wr_en   = 1'b1;
                w_ptr_nxt = w_ptr_inc;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (w_scl_fall) begin
            w_cnt_nxt = '0;
            if (r_shreg[0]) begin
              w_state_nxt = RD_DATA;
              w_sh_nxt    = {w_cur_byte[6:0], 1'b0};
              w_en_nxt    = w_cur_byte[7];
            end else begin
              w_state_nxt = WR_DATA;
              w_first_nxt = 1'b1;
              w_en_nxt    = 1'b1;
            end
          end
        end
        WR_ACK: begin
          if (w_scl_fall) begin
            w_state_nxt = WR_DATA;
            w_cnt_nxt   = '0;
            w_en_nxt    = 1'b1;
          end
        end
        RD_DATA: begin
          if (w_scl_rise) begin
            w_cnt_nxt = r_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_cnt == 4'd8) begin
              w_state_nxt = RD_ACK;
              w_en_nxt    = 1'b1;
            end else begin
              w_en_nxt = r_shreg[7];
              w_sh_nxt = {r_shreg[6:0], 1'b0};
            end
          end
        end
        RD_ACK: begin
          if (w_scl_rise && w_sda == NACK_LVL) begin
            w_state_nxt = IDLE;
          end else if (w_scl_fall) begin
            w_state_nxt = RD_DATA;
            w_ptr_nxt   = w_ptr_inc;
            w_cnt_nxt   = '0;
            w_sh_nxt    = {w_nxt_byte[6:0], 1'b0};
            w_en_nxt    = w_nxt_byte[7];
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_shreg  <= '0;
      r_ptr    <= '0;
      r_first  <= 1'b0;
      r_sda_en <= 1'b1;
      r_sda_o  <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shreg  <= w_sh_nxt;
      r_ptr    <= w_ptr_nxt;
      r_first  <= w_first_nxt;
      r_sda_en <= w_en_nxt;
      r_sda_o  <= w_en_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < REG_DEPTH; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[r_ptr] <= r_shreg;
    end
  end

  assign SDA_in_en = r_sda_en;
  assign SDA_o     = r_sda_o;

endmodule

// File: tb/tb_i2c_slave.sv
// Bus-level bench: the master pushes expected SDA behaviour per SCL pulse, a monitor checks it.
module tb_i2c_slave;

  localparam int TQ = 100;

  logic clk   = 1'b0;
  logic rstn  = 1'b1;
  logic r_scl = 1'b1;
  logic m_sda = 1'b1;
  logic SDA_in_en, SDA_o, w_bus;

  assign w_bus = m_sda & (SDA_in_en | SDA_o);

  i2c_slave #(.SLAVE_ADDR(7'h53), .REG_DEPTH(16)) dut (
    .clk(clk), .rstn(rstn), .SCL_i(r_scl), .SDA_i(w_bus),
    .SDA_in_en(SDA_in_en), .SDA_o(SDA_o)
  );

  always #5 clk = ~clk;

  // kind 0: compare {SDA_in_en,SDA_o} to exp; kind 1: compare bus SDA to exp[0]
  typedef struct packed {
    logic       kind;
    logic [1:0] exp;
    logic       chk_rel;
  } rec_t;

  rec_t  q_rec[$];
  string q_nm[$];
  int    n_chk = 0;
  int    n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic kind, input logic [1:0] exp, input logic rel, input string nm);
    rec_t r;
    r.kind = kind; r.exp = exp; r.chk_rel = rel;
    q_rec.push_back(r);
    q_nm.push_back(nm);
  endtask

  task automatic clk_bit(input logic b);
    m_sda = b; #TQ;
    r_scl = 1'b1; #(2*TQ);
    r_scl = 1'b0; #TQ;
  endtask

  task automatic start_c();
    m_sda = 1'b1; #TQ;
    r_scl = 1'b1; #TQ;
    m_sda = 1'b0; #TQ;
    r_scl = 1'b0; #TQ;
  endtask

  task automatic stop_c();
    m_sda = 1'b0; #TQ;
    r_scl = 1'b1; #TQ;
    m_sda = 1'b1; #(2*TQ);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic acked, input logic rel, input string tag);
    for (int i = 7; i >= 0; i--) begin
      push(1'b0, 2'b11, 1'b0, $sformatf("%s bit%0d", tag, i));
      clk_bit(b[i]);
    end
    push(1'b0, acked ? 2'b00 : 2'b11, rel, {tag, " ack"});
    clk_bit(1'b1);
  endtask

  task automatic read_byte(input logic [7:0] e, input logic mack, input string tag);
    for (int i = 7; i >= 0; i--) begin
      push(1'b1, {1'b0, e[i]}, 1'b0, $sformatf("%s bit%0d", tag, i));
      clk_bit(1'b1);
    end
    push(1'b0, 2'b11, 1'b0, {tag, " mack"});
    clk_bit(!mack);
  endtask

  task automatic sample(input rec_t r, input string nm);
    if (r.kind) chk(nm, {31'd0, w_bus}, {31'd0, r.exp[0]});
    else        chk(nm, {30'd0, SDA_in_en, SDA_o}, {30'd0, r.exp});
  endtask

  initial begin : monitor
    rec_t  r;
    string nm;
    forever begin
      @(posedge r_scl);
      if (q_rec.size() != 0) begin
        r  = q_rec.pop_front();
        nm = q_nm.pop_front();
        #20;
        sample(r, {nm, " early"});
        #(2*TQ - 40);
        sample(r, {nm, " late"});
        if (r.chk_rel) begin
          @(negedge r_scl);
          #30;
          chk({nm, " release"}, {31'd0, SDA_in_en}, 32'd1);
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL timeout: got no end expected summary");
    $fatal(1);
  end

  initial begin : stim
    logic       drove;
    logic [7:0] a;
    #2 rstn = 1'b0;
    #21;
    chk("reset in_en", {31'd0, SDA_in_en}, 32'd1);
    chk("reset sda_o", {31'd0, SDA_o}, 32'd1);
    #20 rstn = 1'b1;
    drove = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (!SDA_in_en) drove = 1'b1;
    end
    chk("no drive without start", {31'd0, drove}, 32'd0);

    // address match, write direction
    start_c(); send_byte(8'hA6, 1'b1, 1'b1, "match addr"); stop_c();

    // address mismatch stays silent through data bytes
    start_c();
    send_byte(8'hA4, 1'b0, 1'b0, "mism addr");
    send_byte(8'h02, 1'b0, 1'b0, "mism d0");
    send_byte(8'h00, 1'b0, 1'b0, "mism d1");
    stop_c();

    // write ptr 2: A5, 3C then read back
    start_c();
    send_byte(8'hA6, 1'b1, 1'b0, "wr addr");
    send_byte(8'h02, 1'b1, 1'b0, "wr ptr");
    send_byte(8'hA5, 1'b1, 1'b0, "wr d0");
    send_byte(8'h3C, 1'b1, 1'b0, "wr d1");
    stop_c();
    start_c();
    send_byte(8'hA6, 1'b1, 1'b0, "rd waddr");
    send_byte(8'h02, 1'b1, 1'b0, "rd ptr");
    start_c();
    send_byte(8'hA7, 1'b1, 1'b0, "rd raddr");
    read_byte(8'hA5, 1'b1, "rd d0");
    read_byte(8'h3C, 1'b0, "rd d1");
    stop_c();
    #TQ;
    chk("idle after read", {31'd0, SDA_in_en}, 32'd1);

    // pointer wrap 0x0F -> 0x00
    start_c();
    send_byte(8'hA6, 1'b1, 1'b0, "wrap waddr");
    send_byte(8'h0F, 1'b1, 1'b0, "wrap ptr");
    send_byte(8'h11, 1'b1, 1'b0, "wrap d0");
    send_byte(8'h22, 1'b1, 1'b0, "wrap d1");
    stop_c();
    start_c();
    send_byte(8'hA6, 1'b1, 1'b0, "wrap rwaddr");
    send_byte(8'h0F, 1'b1, 1'b0, "wrap rptr");
    start_c();
    send_byte(8'hA7, 1'b1, 1'b0, "wrap raddr");
    read_byte(8'h11, 1'b1, "wrap r0");
    read_byte(8'h22, 1'b0, "wrap r1");
    stop_c();

    // reset while the address ACK is driven
    a = 8'hA6;
    start_c();
    for (int i = 7; i >= 0; i--) begin
      push(1'b0, 2'b11, 1'b0, $sformatf("rst addr bit%0d", i));
      clk_bit(a[i]);
    end
    m_sda = 1'b1; #TQ;
    r_scl = 1'b1; #TQ;
    chk("ack driven before reset", {31'd0, SDA_in_en}, 32'd0);
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("async release in_en", {31'd0, SDA_in_en}, 32'd1);
    chk("async release sda_o", {31'd0, SDA_o}, 32'd1);
    #40 rstn = 1'b1;
    #TQ r_scl = 1'b0;
    #TQ;
    stop_c();
    start_c();
    send_byte(8'hA6, 1'b1, 1'b0, "post waddr");
    send_byte(8'h02, 1'b1, 1'b0, "post ptr");
    start_c();
    send_byte(8'hA7, 1'b1, 1'b0, "post raddr");
    read_byte(8'h00, 1'b0, "post r0");
    stop_c();

    #(4*TQ);
    chk("scoreboard drained", q_rec.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous, active-low reset, rstn.
REQ-002 Parameter SLAVE_ADDR SHALL default to 7'h53 and is the 7-bit device address the block answers to.
REQ-003 Parameter REG_DEPTH SHALL default to 16 and is the number of internal 8-bit registers (power of two, 2..256).
REQ-004 clk  input  1  system clock, at least 8x the SCL frequency.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 SCL_i  input  1  I2C clock from the pad, asynchronous to clk.
REQ-007 SDA_i  input  1  I2C data from the pad, asynchronous to clk.
REQ-008 SDA_in_en  output  1  1 = pad released (input mode); 0 = pad driven with SDA_o.
REQ-009 SDA_o  output  1  value driven onto SDA when SDA_in_en=0; registered.

Function
REQ-010 SCL_i and SDA_i SHALL each pass through a 2-flop synchronizer; all logic SHALL use the synchronized copies and their registered previous values for edge detection.
REQ-011 START SHALL be detected as a synchronized SDA falling edge while synchronized SCL is high; STOP as a synchronized SDA rising edge while SCL is high.
REQ-012 States SHALL be IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
REQ-013 START from any state (including a repeated start) SHALL clear the bit counter and enter ADDR; STOP from any state SHALL enter IDLE and release SDA on the next clk.
REQ-014 Incoming bits SHALL be sampled MSB-first on the synchronized SCL rising edge; outgoing bits and ACK drive SHALL change only on the synchronized SCL falling edge.
REQ-015 After 8 address bits: on a match of bits[7:1] with SLAVE_ADDR, the block SHALL enter ADDR_ACK; on a mismatch it SHALL enter IDLE and leave SDA released until the next START.
REQ-016 In ADDR_ACK and WR_ACK, the block SHALL drive SDA low from the 8th SCL falling edge to the 9th SCL falling edge (SDA_in_en=0, SDA_o=0).
REQ-017 After the address ACK, R/W=0 SHALL enter WR_DATA; R/W=1 SHALL enter RD_DATA and load the shift register with reg[ptr].
REQ-018 The first byte of a write transfer SHALL load the register pointer ptr (modulo REG_DEPTH); each later byte SHALL be written to reg[ptr], after which ptr increments and wraps from REG_DEPTH-1 to 0.
REQ-019 In RD_DATA, for each bit the block SHALL drive SDA low for a 0 and release SDA for a 1 (open-drain); SDA_o SHALL be 0 whenever SDA_in_en=0.
REQ-020 After 8 read bits, the block SHALL release SDA and sample the master's ACK in RD_ACK.
REQ-021 On a master ACK (low) in RD_ACK, ptr SHALL increment, the next byte SHALL be loaded, and the block SHALL return to RD_DATA.
REQ-022 On a master NACK (high) in RD_ACK, the block SHALL enter IDLE with SDA released.
REQ-023 A STOP or START occurring mid-byte SHALL discard the partial byte and leave the registers unchanged.

Reset
REQ-024 rstn=0 SHALL immediately (asynchronously) set SDA_in_en=1, SDA_o=1, state=IDLE, ptr=0, bit counter=0, synchronizer flops=1, and all registers=8'h00.
REQ-025 A reset asserted during an ACK or read bit SHALL release SDA without waiting for clk.

Configuration
REQ-026 When macro I2C_SLAVE_GLITCH_FILTER_EN is defined, each synchronized line SHALL additionally pass a 3-sample filter: the output changes only after 3 consecutive equal samples, adding 2 clk of latency.
REQ-027 Without I2C_SLAVE_GLITCH_FILTER_EN, the plain 2-flop synchronizer SHALL be used, and all other behaviour SHALL be identical.

Structure
REQ-028 Package i2c_slave_pkg SHALL hold the state enumeration, the default address constant 7'h53 and the ACK/NACK level constants.
REQ-029 Sub-module i2c_slave_sync SHALL implement the synchronizer, the optional filter and the rise/fall edge pulses, and SHALL be instantiated once for SCL and once for SDA.

Verification
REQ-030 The bench SHALL cover reset: rstn=0 with SCL=SDA=1 -> SDA_in_en=1, SDA_o=1; after release, no drive without a START.
REQ-031 The bench SHALL cover an address match: START, address 0x53, W -> SDA_in_en=0, SDA_o=0 throughout the 9th SCL high, and SDA_in_en=1 within 3 clk after the 9th SCL fall.
REQ-032 The bench SHALL cover an address mismatch: START, address 0x52, W -> SDA_in_en stays 1 for all 9 clocks and for the following data bytes.
REQ-033 The bench SHALL cover write then read: write ptr 0x02, data 0xA5, 0x3C, STOP; then START 0x53 W, ptr 0x02, repeated START 0x53 R, read with ACK then NACK -> bytes 0xA5 then 0x3C MSB-first, then IDLE.
REQ-034 The bench SHALL cover pointer wrap: write ptr 0x0F, data 0x11, 0x22; read back from ptr 0x0F -> 0x11 then 0x22 (reg 0).
REQ-035 The bench SHALL cover reset mid-operation: rstn low during the address ACK -> SDA_in_en=1 before the next clk edge; a later read of reg 0x02 returns 0x00.
